// File: rtl/imuldiv_int_div_iterative_param.sv
// ---------------------------------------------------------------------------
// imuldiv_int_div_iterative_param
//
// Purpose:
//   Parametrised iterative restoring divider for the imuldiv unit. It produces
//   one quotient bit per cycle and handles signed (div/rem) and unsigned
//   (divu/remu) operation. Divide-by-zero returns quotient = all ones and
//   remainder = dividend. The signed overflow case (most negative / -1)
//   returns quotient = most negative and remainder = 0.
//
// Ports:
//   clk                 in   1    clock, rising edge
//   reset               in   1    asynchronous reset, active low (0 = reset)
//   divreq_msg_fn       in   1    0 = signed div/rem, 1 = unsigned divu/remu
//   divreq_msg_a        in   W    dividend
//   divreq_msg_b        in   W    divisor
//   divreq_val          in   1    request valid
//   divreq_rdy          out  1    request ready
//   divresp_msg_result  out  2W   {remainder, quotient}
//   divresp_val         out  1    response valid
//   divresp_rdy         in   1    response ready
//
// Configuration macro:
//   IMULDIV_DIV_BYPASS_EN - when defined, a zero divisor skips the iterative
//   datapath and jumps straight to DONE with the override result. The result
//   is identical either way; only latency changes.
// ---------------------------------------------------------------------------
module imuldiv_int_div_iterative_param #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           divreq_msg_fn,
  input  logic [W-1:0]   divreq_msg_a,
  input  logic [W-1:0]   divreq_msg_b,
  input  logic           divreq_val,
  output logic           divreq_rdy,
  output logic [2*W-1:0] divresp_msg_result,
  output logic           divresp_val,
  input  logic           divresp_rdy
);

  localparam int CNTW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             fn_q, fn_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             bz_q, bz_d;
  logic [W-1:0]     a_q, a_d;
  logic [2*W:0]     rq_q, rq_d;
  logic [2*W:0]     dv_q, dv_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             rdy_q, rdy_d;
  logic             val_q, val_d;

  logic             aNeg, bNeg, bZero;
  logic [W-1:0]     aMag, bMag;
  logic [2*W:0]     shifted, diff;
  logic             geq;
  logic [W-1:0]     quo, rem, quoFix, remFix;

  // Operand magnitudes; only signed mode looks at the sign bits.
  assign aNeg  = !divreq_msg_fn && divreq_msg_a[W-1];
  assign bNeg  = !divreq_msg_fn && divreq_msg_b[W-1];
  assign bZero = (divreq_msg_b == '0);
  assign aMag  = aNeg ? (~divreq_msg_a + W'(1)) : divreq_msg_a;
  assign bMag  = bNeg ? (~divreq_msg_b + W'(1)) : divreq_msg_b;

  // One restoring step. The divisor sits W bits up, so the trial subtract
  // only touches the remainder half. Its low W bits are zero, which keeps
  // the difference LSB clear for the new quotient bit to be OR-ed in.
  assign shifted = rq_q << 1;
  assign geq     = (shifted >= dv_q);
  assign diff    = shifted - dv_q;

  // Sign correction: quotient follows sa^sb, remainder follows the dividend.
  assign quo    = rq_q[W-1:0];
  assign rem    = rq_q[2*W-1:W];
  assign quoFix = (!fn_q && (sa_q ^ sb_q)) ? (~quo + W'(1)) : quo;
  assign remFix = (!fn_q && sa_q) ? (~rem + W'(1)) : rem;

  // Next-state and datapath update. Ready and valid are registered from the
  // next state so both read as 0 while reset is held. Valid additionally
  // waits one cycle after DONE is entered, and drops on the handshake edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fn_d    = fn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    a_d     = a_q;
    rq_d    = rq_q;
    dv_d    = dv_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (divreq_val && rdy_q) begin
          fn_d    = divreq_msg_fn;
          sa_d    = aNeg;
          sb_d    = bNeg;
          bz_d    = bZero;
          a_d     = divreq_msg_a;
          rq_d    = {{(W+1){1'b0}}, aMag};
          dv_d    = {1'b0, bMag, {W{1'b0}}};
          cnt_d   = '0;
          state_d = CALC;
`ifdef IMULDIV_DIV_BYPASS_EN
          if (bZero) begin
            res_d   = {divreq_msg_a, {W{1'b1}}};
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        rq_d  = geq ? (diff | {{(2*W){1'b0}}, 1'b1}) : shifted;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(W-1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        res_d   = bz_q ? {a_q, {W{1'b1}}} : {remFix, quoFix};
        state_d = DONE;
      end
      DONE: begin
        if (val_q && divresp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
    val_d = (state_q == DONE) && (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fn_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_q     <= '0;
      rq_q    <= '0;
      dv_q    <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fn_q    <= fn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      a_q     <= a_d;
      rq_q    <= rq_d;
      dv_q    <= dv_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
    end
  end

  assign divreq_rdy         = rdy_q;
  assign divresp_val        = val_q;
  assign divresp_msg_result = res_q;

endmodule

// File: tb/tb_imuldiv_int_div_iterative_param.sv
// ---------------------------------------------------------------------------
// tb_imuldiv_int_div_iterative_param
//
// Exercises a 32-bit and an 8-bit instance of the iterative divider. The
// expected {remainder, quotient} comes from a plain-arithmetic reference
// function; latency, hold behaviour and reset abort are checked as well.
// ---------------------------------------------------------------------------
module tb_imuldiv_int_div_iterative_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        fn32, reqVal32, reqRdy32, respVal32, respRdy32;
  logic [31:0] a32, b32;
  logic [63:0] res32;

  logic        fn8, reqVal8, reqRdy8, respVal8, respRdy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int checks   = 0;
  int failures = 0;

  imuldiv_int_div_iterative_param #(.W(32)) dut32 (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (fn32),
    .divreq_msg_a       (a32),
    .divreq_msg_b       (b32),
    .divreq_val         (reqVal32),
    .divreq_rdy         (reqRdy32),
    .divresp_msg_result (res32),
    .divresp_val        (respVal32),
    .divresp_rdy        (respRdy32)
  );

  imuldiv_int_div_iterative_param #(.W(8)) dut8 (
    .clk                (clk),
    .reset              (reset),
    .divreq_msg_fn      (fn8),
    .divreq_msg_a       (a8),
    .divreq_msg_b       (b8),
    .divreq_val         (reqVal8),
    .divreq_rdy         (reqRdy8),
    .divresp_msg_result (res8),
    .divresp_val        (respVal8),
    .divresp_rdy        (respRdy8)
  );

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference divider on w-bit operands using native 64-bit arithmetic.
  // Returns {remainder, quotient} packed in the low 2w bits.
  function automatic logic [63:0] refDiv(input int w, input logic f,
                                         input longint unsigned a, input longint unsigned b);
    longint unsigned mask;
    longint unsigned q, r;
    longint          sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a    = a & mask;
    b    = b & mask;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (f) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = a[w-1] ? (longint'(a) - longint'(64'd1 << w)) : longint'(a);
      sb = b[w-1] ? (longint'(b) - longint'(64'd1 << w)) : longint'(b);
      q  = $unsigned(sa / sb) & mask;
      r  = $unsigned(sa % sb) & mask;
    end
    return (r << w) | q;
  endfunction

  function automatic logic curVal(input int w);
    return (w == 8) ? respVal8 : respVal32;
  endfunction

  function automatic logic curRdy(input int w);
    return (w == 8) ? reqRdy8 : reqRdy32;
  endfunction

  function automatic logic [63:0] curRes(input int w);
    return (w == 8) ? {48'b0, res8} : res32;
  endfunction

  task automatic driveReq(input int w, input logic v, input logic f, input logic [31:0] opA, input logic [31:0] opB);
    if (w == 8) begin
      reqVal8 = v; fn8 = f; a8 = opA[7:0]; b8 = opB[7:0];
    end else begin
      reqVal32 = v; fn32 = f; a32 = opA; b32 = opB;
    end
  endtask

  task automatic setRespRdy(input int w, input logic v);
    if (w == 8) respRdy8 = v;
    else        respRdy32 = v;
  endtask

  // Issues one division, measures latency from the accept edge, optionally
  // holds the response for holdCycles and optionally pulses a second request
  // while the divider is busy. Then completes the response handshake.
  task automatic applyStimulus(input int w, input logic f, input logic [31:0] opA,
                               input logic [31:0] opB, input int holdCycles, input bit intrude);
    logic [63:0]     expRes;
    longint unsigned mask;
    int              expLat;
    int              lat;
    int              guard;
    mask   = (64'd1 << w) - 64'd1;
    expRes = refDiv(w, f, opA, opB);
    expLat = w + 2;
`ifdef IMULDIV_DIV_BYPASS_EN
    if ((longint'(opB) & mask) == 0) expLat = 1;
`endif
    guard = 0;
    while (curRdy(w) !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reqRdyBeforeIssue", curRdy(w), 1);
    driveReq(w, 1'b1, f, opA, opB);
    @(posedge clk); #1;
    driveReq(w, 1'b0, f, opA, opB);
    lat = 0;
    while (curVal(w) !== 1'b1 && lat < 200) begin
      if (intrude && lat == 10) begin
        checkOutput("reqRdyBusy", curRdy(w), 0);
        driveReq(w, 1'b1, ~f, ~opA, opB ^ 32'h5);
      end else begin
        driveReq(w, 1'b0, f, opA, opB);
      end
      @(posedge clk); #1;
      lat++;
    end
    driveReq(w, 1'b0, f, opA, opB);
    checkOutput("respVal", curVal(w), 1);
    checkOutput("latency", lat, expLat);
    checkOutput("result", curRes(w), expRes);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput("holdVal", curVal(w), 1);
      checkOutput("holdResult", curRes(w), expRes);
      checkOutput("holdReqRdy", curRdy(w), 0);
    end
    setRespRdy(w, 1'b1);
    @(posedge clk); #1;
    setRespRdy(w, 1'b0);
    checkOutput("valAfterTake", curVal(w), 0);
    checkOutput("rdyAfterTake", curRdy(w), 1);
    checkOutput("resultRetained", curRes(w), expRes);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        rf;
    logic [31:0] ra, rb;
    int          guard;

    reset = 1'b0;
    driveReq(32, 1'b0, 1'b0, 32'd0, 32'd0);
    driveReq(8, 1'b0, 1'b0, 32'd0, 32'd0);
    respRdy32 = 1'b0;
    respRdy8  = 1'b0;

    // Outputs must be quiet while reset is held.
    #12;
    checkOutput("resetReqRdy", reqRdy32, 0);
    checkOutput("resetRespVal", respVal32, 0);
    checkOutput("resetResult", res32, 0);
    #11 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rdyAfterRelease", reqRdy32, 1);
    checkOutput("rdyAfterRelease8", reqRdy8, 1);

    // Directed cases from the divider's defined corner behaviour.
    applyStimulus(32, 1'b1, 32'd100, 32'd7, 0, 0);
    applyStimulus(32, 1'b0, 32'hFFFFFFF9, 32'd2, 0, 0);
    applyStimulus(32, 1'b0, 32'd7, 32'hFFFFFFFE, 0, 0);
    applyStimulus(32, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    applyStimulus(32, 1'b0, 32'hFFFFFFFB, 32'd0, 0, 0);
    applyStimulus(32, 1'b1, 32'hDEADBEEF, 32'd0, 0, 0);
    applyStimulus(32, 1'b1, 32'hFFFFFFFF, 32'd1, 0, 0);
    applyStimulus(32, 1'b1, 32'd5, 32'hFFFFFFFF, 0, 0);

    // Response held off for ten cycles with a stray request mid-calculation.
    applyStimulus(32, 1'b1, 32'd1000, 32'd13, 10, 1);

    // Randomised operands with weighted divisor corners.
    for (int i = 0; i < 30; i++) begin
      rf = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFFFFFF;
        3:       rb = $urandom_range(1, 100);
        4:       begin rb = 32'hFFFFFFFF; ra = 32'h80000000; end
        default: rb = $urandom;
      endcase
      applyStimulus(32, rf, ra, rb, 0, 0);
    end

    // Reset asserted mid-calculation aborts the division.
    guard = 0;
    while (reqRdy32 !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    driveReq(32, 1'b1, 1'b1, 32'd123456, 32'd77);
    @(posedge clk); #1;
    driveReq(32, 1'b0, 1'b1, 32'd123456, 32'd77);
    repeat (15) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("abortRespVal", respVal32, 0);
    checkOutput("abortReqRdy", reqRdy32, 0);
    checkOutput("abortResult", res32, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rdyAfterAbort", reqRdy32, 1);
    repeat (40) @(posedge clk);
    #1 checkOutput("noStaleResp", respVal32, 0);
    applyStimulus(32, 1'b0, 32'd9, 32'd3, 0, 0);

    // Narrow instance.
    applyStimulus(8, 1'b1, 32'hFF, 32'h10, 0, 0);
    applyStimulus(8, 1'b0, 32'h80, 32'hFF, 0, 0);
    applyStimulus(8, 1'b0, 32'hF9, 32'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
